decoder_cs_arbiter: RTL and testbench

Round-robin chip-select arbiter that shares one 3-to-8 active-low decoder among eight requesters. It accepts per-requester access requests, picks one winner, drives the decoder's select and enable inputs with setup and guard spacing, and holds the selected output active until the requester signals completion. It sits between the peripheral-access masters and the decoder. It guarantees that no two decoder outputs are ever active together and that the select lines never change while the decoder is enabled.

---
 rtl/dec_arb_pkg.sv | 25 ++
 rtl/rr_pick8.sv | 32 +++
 rtl/decoder_cs_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_decoder_cs_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dec_arb_pkg.sv
// Shared definitions for the decoder chip-select arbiter.
//   state_e      : arbiter FSM states
//   NUM_REQ      : number of requesters sharing the decoder
//   IDX_W        : width of a requester index (decoder select width)
//   CNT_W        : width of the setup/guard spacing counter (max value 15)
//   G1_*, G2_*   : decoder enable levels (G1 active-high, G2A/G2B active-low)
package dec_arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 4;

    localparam logic G1_ON  = 1'b1;
    localparam logic G1_OFF = 1'b0;
    localparam logic G2_ON  = 1'b0;
    localparam logic G2_OFF = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StActive,
        StGuard
    } state_e;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker for eight requesters.
// Ports:
//   req_i   : request vector
//   ptr_i   : highest-priority index; scan runs upward from here, wrapping 7 -> 0
//   valid_o : at least one request present
//   index_o : first set request at or after ptr_i (ptr_i when none)
module rr_pick8
    import dec_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   index_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        index_o = ptr_i;
        cand    = ptr_i;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // IDX_W-bit addition wraps naturally from 7 back to 0
            cand = ptr_i + IDX_W'(i);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                index_o = cand;
            end
        end
    end

endmodule

// File: rtl/decoder_cs_arbiter.sv
// Round-robin chip-select arbiter driving one shared 3-to-8 active-low decoder.
// Each grant runs IDLE -> SETUP -> ACTIVE -> GUARD so the select lines are only
// ever changed while the decoder is disabled.
// Ports:
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   req_i[7:0]              : level requests, held until granted
//   done_i[7:0]             : completion; only the current grantee's bit counts
//   select_a/b/c_o          : decoder select = grantee index (a = LSB)
//   g1_en_o                 : decoder active-high enable
//   g2a_en_n_o, g2b_en_n_o  : decoder active-low enables, driven identically
//   grant_o[7:0]            : one-hot grantee, zero when none
//   busy_o                  : high whenever not idle
//   timeout_o               : one-cycle pulse on forced release
// Optional feature: define DEC_ARB_TIMEOUT_EN to force release after MAX_HOLD
// ACTIVE cycles without done; otherwise timeout_o is tied low.
module decoder_cs_arbiter
    import dec_arb_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned GUARD_CYCLES = 1,
    parameter int unsigned MAX_HOLD     = 255
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] done_i,
    output logic               select_a_o,
    output logic               select_b_o,
    output logic               select_c_o,
    output logic               g1_en_o,
    output logic               g2a_en_n_o,
    output logic               g2b_en_n_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o,
    output logic               timeout_o
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               g1_q, g1_d;
    logic               g2_q, g2_d;
    logic               busy_q, busy_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

`ifdef DEC_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               timeout_q, timeout_d;
`else
    logic               unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
`endif

    rr_pick8 u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .index_o (pick_idx)
    );

    // Outputs are registered, so each is set on the edge that enters the state
    // in which it must be valid.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        g1_d    = g1_q;
        g2_d    = g2_q;
        busy_d  = busy_q;
`ifdef DEC_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StSetup;
                    sel_d   = pick_idx;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    ptr_d   = pick_idx + IDX_W'(1);
                    cnt_d   = CNT_W'(SETUP_CYCLES - 1);
                    busy_d  = 1'b1;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StActive;
                    g1_d    = G1_ON;
                    g2_d    = G2_ON;
`ifdef DEC_ARB_TIMEOUT_EN
                    hold_d  = HOLD_W'(MAX_HOLD - 1);
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StActive: begin
                if (done_i[sel_q]) begin
                    state_d = StGuard;
                    g1_d    = G1_OFF;
                    g2_d    = G2_OFF;
                    grant_d = '0;
                    cnt_d   = CNT_W'(GUARD_CYCLES - 1);
`ifdef DEC_ARB_TIMEOUT_EN
                end else if (hold_q == '0) begin
                    state_d   = StGuard;
                    g1_d      = G1_OFF;
                    g2_d      = G2_OFF;
                    grant_d   = '0;
                    cnt_d     = CNT_W'(GUARD_CYCLES - 1);
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
`endif
                end
            end
            StGuard: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            g1_q    <= G1_OFF;
            g2_q    <= G2_OFF;
            busy_q  <= 1'b0;
`ifdef DEC_ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            busy_q  <= busy_d;
`ifdef DEC_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign select_a_o = sel_q[0];
    assign select_b_o = sel_q[1];
    assign select_c_o = sel_q[2];
    assign g1_en_o    = g1_q;
    assign g2a_en_n_o = g2_q;
    assign g2b_en_n_o = g2_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
`ifdef DEC_ARB_TIMEOUT_EN
    assign timeout_o  = timeout_q;
`else
    assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_cs_arbiter.sv
// Directed self-checking bench for decoder_cs_arbiter (SETUP=2, GUARD=1, MAX_HOLD=4).
module tb_decoder_cs_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] done = 8'h00;
    logic       sel_a, sel_b, sel_c;
    logic       g1, g2a_n, g2b_n;
    logic [7:0] grant;
    logic       busy, tmo;

    int checks = 0;
    int errors = 0;

    decoder_cs_arbiter #(
        .SETUP_CYCLES (2),
        .GUARD_CYCLES (1),
        .MAX_HOLD     (4)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_i      (req),
        .done_i     (done),
        .select_a_o (sel_a),
        .select_b_o (sel_b),
        .select_c_o (sel_c),
        .g1_en_o    (g1),
        .g2a_en_n_o (g2a_n),
        .g2b_en_n_o (g2b_n),
        .grant_o    (grant),
        .busy_o     (busy),
        .timeout_o  (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // en=1 means decoder enabled: g1=1, g2a_n=g2b_n=0.
    task automatic chk_out(input string tag, input logic [7:0] exp_grant,
                           input logic [2:0] exp_sel, input logic exp_en,
                           input logic exp_busy, input logic exp_tmo);
        check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
        check({tag, ".sel"}, 32'({sel_c, sel_b, sel_a}), 32'(exp_sel));
        check({tag, ".g1"}, 32'(g1), 32'(exp_en));
        check({tag, ".g2a"}, 32'(g2a_n), 32'(!exp_en));
        check({tag, ".g2b"}, 32'(g2b_n), 32'(!exp_en));
        check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
        check({tag, ".tmo"}, 32'(tmo), 32'(exp_tmo));
    endtask

    initial begin
        // Reset held 3 cycles with all requests pending.
        rst_n = 1'b0;
        req   = 8'hFF;
        step(3);
        chk_out("rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // First grant after release is index 0; done ignored until ACTIVE.
        rst_n = 1'b1;
        step();
        chk_out("first", 8'h01, 3'd0, 1'b0, 1'b1, 1'b0);
        req  = 8'h00;
        done = 8'h01;
        step();
        chk_out("first_setup", 8'h01, 3'd0, 1'b0, 1'b1, 1'b0);
        done = 8'h00;
        step();
        chk_out("first_act", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        done = 8'h01;
        step();
        chk_out("first_guard", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        done = 8'h00;
        step();
        chk_out("first_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Single request from requester 5, done after 4 ACTIVE cycles.
        req = 8'h20;
        step();
        chk_out("r5_grant", 8'h20, 3'b101, 1'b0, 1'b1, 1'b0);
        req = 8'h00;
        step();
        chk_out("r5_setup", 8'h20, 3'b101, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("r5_act1", 8'h20, 3'b101, 1'b1, 1'b1, 1'b0);
        step(3);
        chk_out("r5_act4", 8'h20, 3'b101, 1'b1, 1'b1, 1'b0);
        done = 8'h20;
        step();
        chk_out("r5_guard", 8'h00, 3'b101, 1'b0, 1'b1, 1'b0);
        done = 8'h00;
        step();
        chk_out("r5_idle", 8'h00, 3'b101, 1'b0, 1'b0, 1'b0);

        // Round-robin from pointer 0: all requesting, done always high.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req   = 8'hFF;
        done  = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("rr_grant%0d", i), 32'(grant), 32'(8'h01 << (i % 8)));
            check($sformatf("rr_sel%0d", i), 32'({sel_c, sel_b, sel_a}), 32'(i % 8));
            step(2);
            check($sformatf("rr_en%0d", i), 32'(g1), 32'd1);
            if (i == 8) req = 8'h00;
            step(2);
        end
        done = 8'h00;
        check("rr_idle", 32'(busy), 32'd0);

        // Mis-routed done: grantee 3 ignores done[2].
        req = 8'h08;
        step();
        chk_out("mis_grant", 8'h08, 3'd3, 1'b0, 1'b1, 1'b0);
        req = 8'h00;
        step(2);
        chk_out("mis_act", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
        done = 8'h04;
        step(2);
        chk_out("mis_wrong", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
        done = 8'h08;
        step();
        chk_out("mis_guard", 8'h00, 3'd3, 1'b0, 1'b1, 1'b0);
        done = 8'h00;
        step();

        // Pointer is now 4; request 0 wins after wrap, then reset mid-grant.
        req = 8'h01;
        step();
        chk_out("wrap_grant", 8'h01, 3'd0, 1'b0, 1'b1, 1'b0);
        req = 8'h00;
        step(2);
        chk_out("mrst_act", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        req   = 8'h81;
        step();
        chk_out("mrst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("mrst_ptr0", 8'h01, 3'd0, 1'b0, 1'b1, 1'b0);
        req = 8'h00;
        step(2);
        chk_out("hold_act", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);

`ifdef DEC_ARB_TIMEOUT_EN
        // No done: forced release after 4 ACTIVE cycles.
        step(3);
        chk_out("tmo_pre", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        step();
        chk_out("tmo_fire", 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        step();
        chk_out("tmo_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
`else
        // No done: ACTIVE holds indefinitely and no timeout is signalled.
        step(10);
        chk_out("hold_long", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        done = 8'h01;
        step();
        chk_out("hold_guard", 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        done = 8'h00;
        step();
        chk_out("hold_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
